button_conditioner: RTL



---
 rtl/btn_pkg.sv | 12 +
 rtl/button_conditioner_if.sv | 23 ++
 rtl/sync2.sv | 23 ++
 rtl/button_conditioner.sv | 79 +++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button front end.
package btn_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } btn_state_t;

  localparam int BTN_W               = 3;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned outputs between the board and the decoder.
interface button_conditioner_if;

  logic btnr_raw;
  logic btnl_raw;
  logic btnc_raw;
  logic btnr;
  logic btnl;
  logic btnc;
  logic code_changed;
  logic busy;

  modport master (
    output btnr_raw, btnl_raw, btnc_raw,
    input  btnr, btnl, btnc, code_changed, busy
  );

  modport slave (
    input  btnr_raw, btnl_raw, btnc_raw,
    output btnr, btnl, btnc, code_changed, busy
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs, any width.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes and debounces the three buttons as one vector for the decoder.
//   state    | meaning
//   STABLE   | sync matches the committed vector; nothing pending
//   SETTLING | a candidate vector is being timed before commit
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input logic                   clk,
  input logic                   rst_n,
  button_conditioner_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [BTN_W-1:0] raw;
  logic [BTN_W-1:0] sync;
  logic [BTN_W-1:0] stable;
  logic [BTN_W-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic             code_changed;
  btn_state_t       state;

  assign raw = {bus.btnr_raw, bus.btnl_raw, bus.btnc_raw};

  sync2 #(.W(BTN_W)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (raw),
    .q     (sync)
  );

  // Whole vector commits at once so the decoder never sees a partial combination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= STABLE;
      stable       <= '0;
      cand         <= '0;
      cnt          <= '0;
      code_changed <= 1'b0;
    end else begin
      code_changed <= 1'b0;
      unique case (state)
        STABLE: begin
          if (sync != stable) begin
            cand  <= sync;
            cnt   <= '0;
            state <= SETTLING;
          end
        end
        SETTLING: begin
          if (sync == stable) begin
            cnt   <= '0;
            state <= STABLE;
          end else if (sync != cand) begin
            cand <= sync;
            cnt  <= '0;
          end else if (cnt == CNT_LAST) begin
            stable       <= cand;
            code_changed <= 1'b1;
            state        <= STABLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= STABLE;
      endcase
    end
  end

  assign bus.btnr         = stable[2];
  assign bus.btnl         = stable[1];
  assign bus.btnc         = stable[0];
  assign bus.code_changed = code_changed;
  assign bus.busy         = (state == SETTLING);

endmodule
